dec_scan_seq: RTL

//  Registered, parametrised AW-to-2**AW one-hot decoder with a valid/ready load path and an

---
 rtl/dec_scan_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dec_scan_seq.sv
// dec_scan_seq: registered AW-to-2**AW one-hot decoder with a valid/ready load
// path and an auto-scan mode that walks the one-hot output with a programmable
// dwell. One cycle of output latency.
//
// Optional feature: define DEC_ONEHOT_CHK_EN to build a sticky one-hot checker
// on the registered output (err). Without it err is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs off, y_valid=0
// LOAD  | y holds the last accepted code, y_valid=1
// SCAN  | y walks 1<<idx, each code held dwell_r+1 cycles, busy=1
module dec_scan_seq #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              scan_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_addr,
  input  logic [DW-1:0]     dwell,
  output logic [2**AW-1:0]  y,
  output logic              y_valid,
  output logic              busy,
  output logic              cnt_wrap,
  output logic              err
);

  localparam int NW = 2**AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   y_nxt;
  logic [AW-1:0]   idx, idx_nxt, idx_inc;
  logic [DW-1:0]   dwell_r, dwell_r_nxt;
  logic [DW-1:0]   dwell_cnt, dwell_cnt_nxt;
  logic            wrap_nxt;

  function automatic logic [NW-1:0] onehot(input logic [AW-1:0] a);
    onehot = {{(NW-1){1'b0}}, 1'b1} << a;
  endfunction

  // Load is only offered when enabled, not scanning, and scan not requested.
  assign in_ready = en & ~scan_mode & (state != SCAN);
  assign y_valid  = (state != IDLE);
  assign busy     = (state == SCAN);
  assign idx_inc  = idx + 1'b1;

  // State and datapath registers; everything clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= '0;
      idx       <= '0;
      dwell_r   <= '0;
      dwell_cnt <= '0;
      cnt_wrap  <= 1'b0;
    end else begin
      state     <= state_nxt;
      y         <= y_nxt;
      idx       <= idx_nxt;
      dwell_r   <= dwell_r_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      cnt_wrap  <= wrap_nxt;
    end
  end

  // Next-state and next-output decode; en=0 beats scan_mode, scan beats load.
  always_comb begin
    state_nxt     = state;
    y_nxt         = y;
    idx_nxt       = idx;
    dwell_r_nxt   = dwell_r;
    dwell_cnt_nxt = dwell_cnt;
    wrap_nxt      = 1'b0;

    if (!en) begin
      state_nxt     = IDLE;
      y_nxt         = '0;
      idx_nxt       = '0;
      dwell_cnt_nxt = '0;
    end else if (scan_mode) begin
      if (state != SCAN) begin
        // scan start: first code is 0 and does not count as a wrap
        state_nxt     = SCAN;
        idx_nxt       = '0;
        y_nxt         = onehot('0);
        dwell_r_nxt   = dwell;
        dwell_cnt_nxt = '0;
      end else if (dwell_cnt == dwell_r) begin
        idx_nxt       = idx_inc;
        y_nxt         = onehot(idx_inc);
        dwell_cnt_nxt = '0;
        wrap_nxt      = (idx_inc == '0);
      end else begin
        dwell_cnt_nxt = dwell_cnt + 1'b1;
      end
    end else if (state == SCAN) begin
      // leaving scan drops the index so the next scan restarts at code 0
      state_nxt     = IDLE;
      y_nxt         = '0;
      idx_nxt       = '0;
      dwell_cnt_nxt = '0;
    end else if (in_valid) begin
      state_nxt = LOAD;
      y_nxt     = onehot(in_addr);
    end
  end

`ifdef DEC_ONEHOT_CHK_EN
  logic [AW:0] y_pop;

  // Population count of the registered output.
  always_comb begin
    y_pop = '0;
    for (int i = 0; i < NW; i++) begin
      y_pop = y_pop + {{AW{1'b0}}, y[i]};
    end
  end

  // Sticky flag: any live cycle whose output is not exactly one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (y_valid && (y_pop != {{AW{1'b0}}, 1'b1})) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
